func_call_responder: RTL and testbench
======================================

Name: func_call_responder

Overview:
- Callee end of the function-call request/response interface: services calls issued by a caller module.
- Each request carries a call ID and three argument operands. The block queues requests in order and evaluates result = arg0 + arg1 + arg2.
- Results are returned with the matching ID over a valid/ready response channel.
- Sits behind an instantiated module boundary; the caller's call site drives the request channel and consumes the response.

Parameters:
ARG_W, 8, width of each argument operand
ID_W, 4, width of call ID tag
DEPTH, 4, request FIFO depth (power of 2, >= 2)
CNT_W, 16, width of completed-call counter

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  caller presents a call
req_ready  output  1  responder can accept a call
req_id  input  ID_W  call tag
req_arg0  input  ARG_W  first argument
req_arg1  input  ARG_W  second argument
req_arg2  input  ARG_W  third argument
rsp_valid  output  1  result available
rsp_ready  input  1  caller accepts result
rsp_id  output  ID_W  tag of returned call
rsp_result  output  ARG_W+2  sum of the three arguments
busy  output  1  FIFO non-empty or FSM not IDLE
call_count  output  CNT_W  number of completed responses

Behaviour:
- Reset (async, active-high) forces:
  - FSM to IDLE; FIFO pointers and count to 0.
  - rsp_valid=0, rsp_id=0, rsp_result=0, call_count=0, busy=0, req_ready=1.
- Reset mid-operation discards all queued and in-flight calls; no response is emitted for them.
- Request handshake:
  - Push occurs when req_valid && req_ready.
  - req_ready = !fifo_full, registered-count based. No same-cycle pop bypass: a full FIFO deasserts req_ready even if a pop occurs that cycle.
  - Simultaneous push and pop while not full: both happen, count unchanged.
  - A push while full cannot occur (req_ready=0); the caller must hold its request.
- FIFO:
  - DEPTH entries of {id, arg0, arg1, arg2}; strict in-order.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- FSM states:
  - IDLE: if FIFO non-empty, pop head into arg registers and go to EVAL; else stay.
  - EVAL: rsp_result <= zero-extended arg0+arg1+arg2 (ARG_W+2 bits, no overflow possible); rsp_id <= tag; rsp_valid <= 1; go to RESP.
  - RESP: hold rsp_valid, rsp_id and rsp_result stable until rsp_ready. On handshake: call_count += 1 (wraps at 2^CNT_W), rsp_valid <= 0. Then, if FIFO non-empty, pop in the same cycle and go to EVAL; else go to IDLE.
- Latency: request accepted in cycle 0 into an empty idle block -> pop in cycle 1 -> EVAL in cycle 2 -> rsp_valid high in cycle 3.
- Throughput: with rsp_ready held high, one response every 2 cycles.
- The response channel obeys valid/ready rules: rsp_valid is never dropped without a handshake, and payload never changes while rsp_valid && !rsp_ready.
- busy = (state != IDLE) || (count != 0).

Decomposition:
- Shared package `func_call_pkg`:
  - FSM state encodings: IDLE=2'd0, EVAL=2'd1, RESP=2'd2.
  - Request-entry field offsets and packed width ID_W+3*ARG_W.
  - Result-width function ARG_W+2.
- Sub-module `func_call_req_fifo`: parameterised synchronous FIFO with async reset. Ports: push, pop, wdata, rdata, full, empty, count.
- FSM, adder and counter live in the top-level module.

Test Plan:
- Reset, then a single call with id=3, args 8'h01, 8'h02, 8'h03 -> rsp_valid rises 3 cycles after acceptance with rsp_id=3, rsp_result=10'd6; call_count=1 after the handshake.
- Max operands: args 8'hFF, 8'hFF, 8'hFF -> rsp_result=10'h2FD, with no truncation.
- Backpressure: rsp_ready=0, then 5 calls offered -> 4 accepted into the FIFO and 1 taken into EVAL. The 6th call sees req_ready=0. rsp_id/rsp_result stay stable for 20 cycles. After rsp_ready=1, all responses return in order, one every 2 cycles.
- Pointer wrap: 10 back-to-back calls with ids 0..9 and args (i, i, i) under rsp_ready=1 -> results 3*i in order; FIFO pointers wrap correctly; call_count=10.
- Reset mid-operation: assert reset while in RESP with 2 calls queued -> rsp_valid=0 immediately (async). After release: busy=0, call_count=0, no stale responses; a fresh call id=7 returns correctly.
- Counter wrap: preload via 65536 calls (CNT_W=16) -> call_count returns to 0.

Source files
------------

// File: rtl/func_call_pkg.sv
// Shared definitions for the function-call responder: FSM state encoding,
// request-entry layout {id, arg0, arg1, arg2} and derived widths.
package func_call_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_e;

  // Packed request entry width: id on top, then arg0, arg1, arg2 at the LSBs.
  function automatic int entry_width(input int id_w, input int arg_w);
    return id_w + 3 * arg_w;
  endfunction

  // Field offsets inside a packed request entry (arg2 sits at bit 0).
  function automatic int arg1_lsb(input int arg_w);
    return arg_w;
  endfunction

  function automatic int arg0_lsb(input int arg_w);
    return 2 * arg_w;
  endfunction

  function automatic int id_lsb(input int arg_w);
    return 3 * arg_w;
  endfunction

  // Sum of three ARG_W operands never needs more than two extra bits.
  function automatic int result_width(input int arg_w);
    return arg_w + 2;
  endfunction

endpackage

// File: rtl/func_call_req_fifo.sv
// In-order request FIFO with power-of-two depth, wrapping pointers and a
// registered occupancy count used for full/empty.
module func_call_req_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next pointer/count: pointers wrap naturally at DEPTH; simultaneous push
  // and pop leave the count unchanged.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; entries are only
    // read once the count says they were written, and leaving it unreset lets
    // it map onto plain RAM/flops without a reset tree.
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/func_call_responder.sv
// Callee side of the function-call interface: queues {id, arg0, arg1, arg2}
// requests, evaluates arg0+arg1+arg2 and returns the result with its id over
// a valid/ready response channel, counting completed calls.
module func_call_responder
  import func_call_pkg::*;
#(
  parameter int ARG_W = 8,
  parameter int ID_W  = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ID_W-1:0]    req_id,
  input  logic [ARG_W-1:0]   req_arg0,
  input  logic [ARG_W-1:0]   req_arg1,
  input  logic [ARG_W-1:0]   req_arg2,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [ARG_W+1:0]   rsp_result,
  output logic               busy,
  output logic [CNT_W-1:0]   call_count
);

  localparam int ENTRY_W = entry_width(ID_W, ARG_W);
  localparam int RES_W   = result_width(ARG_W);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int A1_LSB  = arg1_lsb(ARG_W);
  localparam int A0_LSB  = arg0_lsb(ARG_W);
  localparam int ID_LSB  = id_lsb(ARG_W);

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_wdata, fifo_rdata;
  logic [PTR_W:0]     fifo_count;

  state_e             state_q, state_d;
  logic [ARG_W-1:0]   arg0_q, arg0_d, arg1_q, arg1_d, arg2_q, arg2_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [RES_W-1:0]   rsp_result_q, rsp_result_d;
  logic [CNT_W-1:0]   call_count_q, call_count_d;
  logic [RES_W-1:0]   sum;

  // Ready depends only on the registered count: a full FIFO stays not-ready
  // even in a cycle where the FSM pops.
  assign req_ready  = !fifo_full;
  assign fifo_push  = req_valid && req_ready;
  assign fifo_wdata = {req_id, req_arg0, req_arg1, req_arg2};

  func_call_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_req_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign sum = RES_W'(arg0_q) + RES_W'(arg1_q) + RES_W'(arg2_q);

  // FSM next state: pop into operand registers, evaluate, then hold the
  // response until the caller takes it (popping the next call in that cycle).
  always_comb begin
    state_d      = state_q;
    fifo_pop     = 1'b0;
    arg0_d       = arg0_q;
    arg1_d       = arg1_q;
    arg2_d       = arg2_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    call_count_d = call_count_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = EVAL;
        end
      end
      EVAL: begin
        rsp_result_d = sum;
        rsp_id_d     = id_q;
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          call_count_d = call_count_q + CNT_W'(1);
          rsp_valid_d  = 1'b0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = EVAL;
          end else begin
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (fifo_pop) begin
      id_d   = fifo_rdata[ID_LSB +: ID_W];
      arg0_d = fifo_rdata[A0_LSB +: ARG_W];
      arg1_d = fifo_rdata[A1_LSB +: ARG_W];
      arg2_d = fifo_rdata[0 +: ARG_W];
    end
  end

  // FSM, operand, response and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      arg0_q       <= '0;
      arg1_q       <= '0;
      arg2_q       <= '0;
      id_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      call_count_q <= '0;
    end else begin
      state_q      <= state_d;
      arg0_q       <= arg0_d;
      arg1_q       <= arg1_d;
      arg2_q       <= arg2_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      call_count_q <= call_count_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign call_count = call_count_q;
  assign busy       = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_func_call_responder.sv
// Self-checking bench for func_call_responder: table-driven single calls,
// then backpressure, pointer wrap, mid-operation reset and counter wrap.
module tb_func_call_responder;

  localparam int ARG_W = 8;
  localparam int ID_W  = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = 6;   // narrow counter so the wrap is reachable quickly

  logic               clk, reset;
  logic               req_valid, req_ready;
  logic [ID_W-1:0]    req_id;
  logic [ARG_W-1:0]   req_arg0, req_arg1, req_arg2;
  logic               rsp_valid, rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [ARG_W+1:0]   rsp_result;
  logic               busy;
  logic [CNT_W-1:0]   call_count;

  func_call_responder #(
    .ARG_W (ARG_W), .ID_W (ID_W), .DEPTH (DEPTH), .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_id     (req_id),
    .req_arg0   (req_arg0),
    .req_arg1   (req_arg1),
    .req_arg2   (req_arg2),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .busy       (busy),
    .call_count (call_count)
  );

  typedef struct {
    logic [ID_W-1:0]  id;
    logic [ARG_W-1:0] a0, a1, a2;
    logic [ARG_W+1:0] res;
  } vec_t;

  typedef struct {
    logic [ID_W-1:0]  id;
    logic [ARG_W+1:0] res;
  } exp_t;

  exp_t  sb[$];
  int    hs_cyc[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  bit    stable_en;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Response monitor: compares each handshake against the scoreboard and
  // checks that a stalled response holds its payload.
  initial begin : monitor
    bit               stalled;
    logic [ID_W-1:0]  prev_id;
    logic [ARG_W+1:0] prev_res;
    exp_t             e;
    stalled = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stalled = 0;
      end else begin
        if (stable_en && stalled) begin
          check("stall_valid",  32'(rsp_valid),  32'd1);
          check("stall_id",     32'(rsp_id),     32'(prev_id));
          check("stall_result", 32'(rsp_result), 32'(prev_res));
        end
        if (rsp_valid && rsp_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_rsp", 32'(rsp_valid), 32'd0);
          end else begin
            e = sb.pop_front();
            check("rsp_id",     32'(rsp_id),     32'(e.id));
            check("rsp_result", 32'(rsp_result), 32'(e.res));
            hs_cyc.push_back(cyc);
          end
        end
        stalled  = rsp_valid && !rsp_ready;
        prev_id  = rsp_id;
        prev_res = rsp_result;
      end
    end
  end

  // Offer one call, hold it until accepted, record its expected response.
  task automatic send(input logic [ID_W-1:0] id, input logic [ARG_W-1:0] a0,
                      input logic [ARG_W-1:0] a1, input logic [ARG_W-1:0] a2,
                      input logic [ARG_W+1:0] res);
    int   t;
    exp_t e;
    req_valid = 1'b1;
    req_id    = id;
    req_arg0  = a0;
    req_arg1  = a1;
    req_arg2  = a2;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      check("req_accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    e.id  = id;
    e.res = res;
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Wait (bounded) until every expected response has been returned.
  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 400) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    vec_t vecs[5];
    int   lat;
    int   t;
    logic [ARG_W-1:0] r0, r1, r2;

    vecs[0] = '{4'd3,  8'h01, 8'h02, 8'h03, 10'd6};
    vecs[1] = '{4'd5,  8'hFF, 8'hFF, 8'hFF, 10'h2FD};
    vecs[2] = '{4'd0,  8'h00, 8'h00, 8'h00, 10'd0};
    vecs[3] = '{4'd15, 8'h80, 8'h7F, 8'h01, 10'h100};
    vecs[4] = '{4'd9,  8'hFF, 8'h00, 8'h01, 10'h100};

    clk = 0; reset = 1; req_valid = 0; rsp_ready = 1; stable_en = 1;
    req_id = '0; req_arg0 = '0; req_arg1 = '0; req_arg2 = '0;
    do_reset();

    check("rst_rsp_valid",  32'(rsp_valid),  32'd0);
    check("rst_rsp_id",     32'(rsp_id),     32'd0);
    check("rst_rsp_result", 32'(rsp_result), 32'd0);
    check("rst_call_count", 32'(call_count), 32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_req_ready",  32'(req_ready),  32'd1);

    // Single calls: latency, result and completed-call count.
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].id, vecs[i].a0, vecs[i].a1, vecs[i].a2, vecs[i].res);
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!rsp_valid && lat < 10);
      check("latency", 32'(lat), 32'd3);
      drain();
      check("count_after_call", 32'(call_count), 32'(i + 1));
      check("idle_not_busy",    32'(busy),       32'd0);
    end

    // Backpressure: 5 calls fill EVAL/RESP plus the whole FIFO.
    do_reset();
    rsp_ready = 1'b0;
    for (int i = 1; i <= 5; i++)
      send(4'(i), 8'(i), 8'(2 * i), 8'(3 * i), 10'(6 * i));
    req_valid = 1'b1;
    req_id = 4'd6; req_arg0 = 8'h11; req_arg1 = 8'h22; req_arg2 = 8'h33;
    repeat (20) @(negedge clk);
    check("full_req_ready", 32'(req_ready),  32'd0);
    check("full_busy",      32'(busy),       32'd1);
    check("held_rsp_id",    32'(rsp_id),     32'd1);
    check("held_rsp_res",   32'(rsp_result), 32'd6);
    check("held_count",     32'(call_count), 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    hs_cyc.delete();
    rsp_ready = 1'b1;
    drain();
    check("bp_rsp_total", 32'(hs_cyc.size()), 32'd5);
    for (int i = 1; i < hs_cyc.size(); i++)
      check("rsp_gap", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd2);
    check("bp_count", 32'(call_count), 32'd5);

    // Pointer wrap: 10 back-to-back calls.
    do_reset();
    for (int i = 0; i < 10; i++)
      send(4'(i), 8'(i), 8'(i), 8'(i), 10'(3 * i));
    drain();
    check("wrap_count", 32'(call_count), 32'd10);

    // Reset while a response is pending and two calls are queued.
    rsp_ready = 1'b0;
    send(4'd1, 8'd1, 8'd1, 8'd1, 10'd3);
    send(4'd2, 8'd2, 8'd2, 8'd2, 10'd6);
    send(4'd3, 8'd3, 8'd3, 8'd3, 10'd9);
    t = 0;
    while (!rsp_valid && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("pre_reset_valid", 32'(rsp_valid), 32'd1);
    stable_en = 0;
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(rsp_valid),  32'd0);
    check("async_rst_busy",  32'(busy),       32'd0);
    check("async_rst_count", 32'(call_count), 32'd0);
    check("async_rst_ready", 32'(req_ready),  32'd1);
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    stable_en = 1;
    rsp_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_busy",  32'(busy),      32'd0);
    check("post_rst_valid", 32'(rsp_valid), 32'd0);
    send(4'd7, 8'h10, 8'h20, 8'h30, 10'h60);
    drain();
    check("post_rst_count", 32'(call_count), 32'd1);

    // Counter wrap at 2^CNT_W completed calls.
    do_reset();
    for (int i = 0; i < (1 << CNT_W); i++) begin
      r0 = 8'($urandom_range(0, 255));
      r1 = 8'($urandom_range(0, 255));
      r2 = 8'($urandom_range(0, 255));
      send(4'(i), r0, r1, r2, 10'(int'(r0) + int'(r1) + int'(r2)));
      if (i == (1 << CNT_W) - 2) begin
        drain();
        check("count_max", 32'(call_count), 32'((1 << CNT_W) - 1));
      end
    end
    drain();
    check("count_wrap", 32'(call_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
